// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared widths and PIPE transmit arbitration types
package common_pkg;

  localparam int BUS_WIDTH_8  = 8;
  localparam int BUS_WIDTH_16 = 16;
  localparam int BUS_WIDTH_32 = 32;

  localparam int NUM_TX_SRC = 3;

  typedef enum logic [1:0] {
    SRC_OS   = 2'd0,
    SRC_DLLP = 2'd1,
    SRC_TLP  = 2'd2,
    SRC_NONE = 2'd3
  } tx_src_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_FLUSH = 2'd2
  } tx_arb_state_t;

endpackage

// File: rtl/pipe_tx_rr_pick.sv
// rtl/pipe_tx_rr_pick.sv - strict priority for source 0, round-robin between 1 and 2
module pipe_tx_rr_pick
  import common_pkg::*;
(
  input  logic [2:0] cand,
  input  logic [1:0] rr_last,
  output logic [1:0] winner,
  output logic       found
);

  logic [1:0] pref;
  logic [1:0] alt;

  always_comb begin
    // The source that did not go last gets first refusal.
    pref   = (rr_last == SRC_TLP) ? SRC_DLLP : SRC_TLP;
    alt    = (pref == SRC_DLLP) ? SRC_TLP : SRC_DLLP;
    winner = SRC_NONE;
    found  = |cand;
    if (cand[0]) begin
      winner = SRC_OS;
    end else if (cand[pref]) begin
      winner = pref;
    end else if (cand[alt]) begin
      winner = alt;
    end
  end

endmodule

// File: rtl/pipe_tx_arbiter.sv
// rtl/pipe_tx_arbiter.sv - packet-atomic arbiter for the MAC-side PIPE transmit bus
module pipe_tx_arbiter
  import common_pkg::*;
#(
  parameter  int DATA_WIDTH    = BUS_WIDTH_32,
  parameter  int MAX_PKT_BEATS = 1024,
  localparam int BYTES         = DATA_WIDTH / 8,
  localparam int CNT_W         = $clog2(MAX_PKT_BEATS + 1)
) (
  input  logic                      pclk,
  input  logic                      reset_n,
  input  logic [2:0]                req_valid,
  output logic [2:0]                req_ready,
  input  logic [2:0]                req_sop,
  input  logic [2:0]                req_eop,
  input  logic [3*DATA_WIDTH-1:0]   req_data,
  input  logic [3*BYTES-1:0]        req_datak,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic [BYTES-1:0]          tx_datak,
  output logic [1:0]                grant,
  output logic                      wdog_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] GNT_NONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       grant_q;
  logic [1:0]       rr_last;
  logic [CNT_W-1:0] beat_cnt;
  logic             wdog_q;

  logic [2:0]       cand;
  logic [1:0]       winner;
  logic             found;
  logic [1:0]       g_idx;
  logic             sel_valid;
  logic             sel_eop;
  logic             xfer;
  logic             drop;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit_max;
  logic [1:0]       rr_next;

  logic [DATA_WIDTH-1:0] src_data  [3];
  logic [BYTES-1:0]      src_datak [3];

  for (genvar i = 0; i < NUM_TX_SRC; i++) begin : g_src
    assign src_data[i]  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign src_datak[i] = req_datak[i*BYTES +: BYTES];
  end

  assign cand = req_valid & req_sop;

  pipe_tx_rr_pick u_pick (
    .cand    (cand),
    .rr_last (rr_last),
    .winner  (winner),
    .found   (found)
  );

  // Folding "no owner" onto source 0 keeps every mux index in range.
  assign g_idx     = (grant_q == GNT_NONE) ? 2'd0 : grant_q;
  assign sel_valid = req_valid[g_idx];
  assign sel_eop   = req_eop[g_idx];

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_datak  = '0;
    req_ready = '0;
    if (state == ST_BUSY) begin
      tx_valid         = sel_valid;
      tx_data          = src_data[g_idx];
      tx_datak         = src_datak[g_idx];
      req_ready[g_idx] = tx_ready;
    end else if (state == ST_FLUSH) begin
      req_ready[g_idx] = 1'b1;
    end
  end

  assign xfer    = tx_valid & tx_ready;
  assign drop    = (state == ST_FLUSH) & sel_valid;
  assign cnt_inc = (beat_cnt == CNT_W'(MAX_PKT_BEATS)) ? beat_cnt : beat_cnt + 1'b1;
  assign hit_max = (cnt_inc == CNT_W'(MAX_PKT_BEATS));
  assign rr_next = (g_idx != 2'd0) ? grant_q : rr_last;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      grant_q  <= GNT_NONE;
      rr_last  <= 2'd2;
      beat_cnt <= '0;
      wdog_q   <= 1'b0;
    end else begin
      wdog_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_q  <= winner;
            state    <= ST_BUSY;
            beat_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (xfer) begin
            if (sel_eop) begin
              state    <= ST_IDLE;
              grant_q  <= GNT_NONE;
              beat_cnt <= '0;
              rr_last  <= rr_next;
            end else if (hit_max) begin
              // Runaway packet: the limit beat is still passed, the tail is discarded.
              wdog_q   <= 1'b1;
              state    <= ST_FLUSH;
              beat_cnt <= cnt_inc;
            end else begin
              beat_cnt <= cnt_inc;
            end
          end
        end
        ST_FLUSH: begin
          if (drop && sel_eop) begin
            state    <= ST_IDLE;
            grant_q  <= GNT_NONE;
            beat_cnt <= '0;
            rr_last  <= rr_next;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= GNT_NONE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign wdog_err = wdog_q;

endmodule

// File: tb/tb_pipe_tx_arbiter.sv
// tb/tb_pipe_tx_arbiter.sv - scoreboard bench for the PIPE transmit arbiter
module tb_pipe_tx_arbiter;

  localparam int DW   = 32;
  localparam int BY   = DW / 8;
  localparam int MAXB = 8;

  logic              pclk;
  logic              reset_n;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [2:0]        req_sop;
  logic [2:0]        req_eop;
  logic [3*DW-1:0]   req_data;
  logic [3*BY-1:0]   req_datak;
  logic              tx_valid;
  logic              tx_ready;
  logic [DW-1:0]     tx_data;
  logic [BY-1:0]     tx_datak;
  logic [1:0]        grant;
  logic              wdog_err;

  pipe_tx_arbiter #(
    .DATA_WIDTH    (DW),
    .MAX_PKT_BEATS (MAXB)
  ) dut (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sop   (req_sop),
    .req_eop   (req_eop),
    .req_data  (req_data),
    .req_datak (req_datak),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_datak  (tx_datak),
    .grant     (grant),
    .wdog_err  (wdog_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [BY-1:0] datak;
  } beat_t;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
    logic [BY-1:0] datak;
  } exp_t;

  beat_t src_q [3][$];
  exp_t  exp_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    wdog_cnt = 0;
  logic [2:0] acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int src, input int id, input int b);
    return {4'(src), 4'hA, 8'(id), 16'(b)};
  endfunction

  // Queue a packet on a source; the first nexp beats are expected on the bus in call order.
  task automatic send_pkt(input int src, input int n, input int id, input int nexp);
    beat_t bt;
    exp_t  e;
    for (int b = 0; b < n; b++) begin
      bt.sop   = (b == 0);
      bt.eop   = (b == n - 1);
      bt.data  = beat_data(src, id, b);
      bt.datak = 4'(b + src);
      src_q[src].push_back(bt);
      if (b < nexp) begin
        e.src   = 2'(src);
        e.data  = bt.data;
        e.datak = bt.datak;
        exp_q.push_back(e);
      end
    end
  endtask

  // Source driver: inputs change only on the falling edge, acceptance is read before the rising edge.
  initial begin
    acc       = '0;
    req_valid = '0;
    req_sop   = '0;
    req_eop   = '0;
    req_data  = '0;
    req_datak = '0;
    forever begin
      @(negedge pclk);
      for (int i = 0; i < 3; i++) begin
        if (!reset_n) src_q[i].delete();
        else if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      for (int i = 0; i < 3; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]            = 1'b1;
          req_sop[i]              = src_q[i][0].sop;
          req_eop[i]              = src_q[i][0].eop;
          req_data[i*DW +: DW]    = src_q[i][0].data;
          req_datak[i*BY +: BY]   = src_q[i][0].datak;
        end else begin
          req_valid[i]            = 1'b0;
          req_sop[i]              = 1'b0;
          req_eop[i]              = 1'b0;
          req_data[i*DW +: DW]    = '0;
          req_datak[i*BY +: BY]   = '0;
        end
      end
      #1;
      acc = reset_n ? (req_valid & req_ready) : 3'b000;
    end
  end

  // Monitor: every transferred beat must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      #2;
      if (reset_n) begin
        if (wdog_err) wdog_cnt++;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h grant %0d expected no beat", tx_data, grant);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 64'(tx_data), 64'(e.data));
            check("tx_datak", 64'(tx_datak), 64'(e.datak));
            check("tx_grant", 64'(grant), 64'(e.src));
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge pclk);
    #2;
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      sync();
      if (grant == g) break;
    end
    if (k == 50) check(name, 64'(grant), 64'(g));
  endtask

  task automatic wait_idle(input string name);
    int k;
    int pend;
    for (k = 0; k < 300; k++) begin
      sync();
      pend = exp_q.size() + src_q[0].size() + src_q[1].size() + src_q[2].size();
      if (pend == 0 && grant == 2'd3) break;
    end
    check({name, "_pending"}, 64'(pend), 64'd0);
    check({name, "_grant"}, 64'(grant), 64'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat;
    reset_n  = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge pclk);
    #2;
    check("rst_grant", 64'(grant), 64'd3);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_wdog", 64'(wdog_err), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    sync();
    reset_n = 1'b1;

    // single TLP, grant one cycle after SOP, four back-to-back beats
    sync();
    send_pkt(2, 4, 1, 4);
    @(negedge pclk);
    #2;
    check("t1_pre_grant", 64'(grant), 64'd3);
    sync();
    check("t1_grant", 64'(grant), 64'd2);
    repeat (3) sync();
    check("t1_hold", 64'(grant), 64'd2);
    sync();
    check("t1_release", 64'(grant), 64'd3);
    wait_idle("t1");

    // simultaneous SOPs: 0 then 1 then 2
    sync();
    send_pkt(0, 2, 2, 2);
    send_pkt(1, 3, 3, 3);
    send_pkt(2, 2, 4, 2);
    wait_idle("t2");

    // rr_last ended on 2, so 1 wins the next contest
    sync();
    send_pkt(1, 2, 5, 2);
    send_pkt(2, 2, 6, 2);
    wait_idle("t2b");

    // req 0 arrives mid TLP and waits for its EOP
    sync();
    send_pkt(2, 6, 7, 6);
    wait_grant(2'd2, "t3_grant2");
    repeat (2) sync();
    send_pkt(0, 2, 8, 2);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        sync();
        if (grant != 2'd2) break;
      end
    end
    check("t3_gap", 64'(grant), 64'd3);
    sync();
    check("t3_grant0", 64'(grant), 64'd0);
    wait_idle("t3");

    // runaway DLLP: 8 beats out, tail flushed
    sync();
    send_pkt(1, 12, 9, 8);
    wait_idle("t4");
    check("t4_wdog_pulses", 64'(wdog_cnt), 64'd1);

    // backpressure pattern 1,0,0,1
    sync();
    send_pkt(2, 3, 10, 3);
    @(negedge pclk);
    sync();
    check("t5_grant", 64'(grant), 64'd2);
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      tx_ready = pat[k];
      #2;
      check("t5_req_ready", 64'(req_ready), 64'({pat[k], 2'b00}));
      check("t5_tx_data", 64'(tx_data), 64'(beat_data(2, 10, (k == 0) ? 0 : 1)));
    end
    wait_idle("t5");

    // asynchronous reset mid packet
    sync();
    send_pkt(2, 6, 11, 0);
    @(negedge pclk);
    tx_ready = 1'b0;
    sync();
    check("t6_grant", 64'(grant), 64'd2);
    @(negedge pclk);
    #3;
    check("t6_pre_valid", 64'(tx_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_async_grant", 64'(grant), 64'd3);
    check("t6_async_valid", 64'(tx_valid), 64'd0);
    check("t6_async_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge pclk);
    sync();
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    sync();
    send_pkt(1, 2, 12, 2);
    @(negedge pclk);
    sync();
    check("t6_regrant", 64'(grant), 64'd1);
    wait_idle("t6");

    check("wdog_total", 64'(wdog_cnt), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_tx_arbiter.md
Name: pipe_tx_arbiter

Overview:
- Shares the MAC-side PIPE transmit data bus (TxData/TxDataK) among three packet sources: ordered-set generator (req 0), DLLP builder (req 1) and TLP builder (req 2).
- Grants are packet-atomic: a grant is taken on SOP and held until EOP, so every packet stays contiguous on the bus.
- Req 0 has strict priority so SKP and other ordered sets are not delayed past the current packet. Reqs 1 and 2 share the remaining bandwidth round-robin.
- Sits between the MAC packet builders and the PIPE interface driver.

Parameters:
- DATA_WIDTH, common_pkg::BUS_WIDTH_32, PIPE data width (8/16/32). BYTES = DATA_WIDTH/8.
- MAX_PKT_BEATS, 1024, watchdog limit on beats per granted packet (≥2).

Ports:
- pclk  in  1  PIPE clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  3  per-source beat valid.
- req_ready  out  3  per-source beat accepted.
- req_sop  in  3  per-source start-of-packet flag.
- req_eop  in  3  per-source end-of-packet flag.
- req_data  in  3*DATA_WIDTH  per-source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_datak  in  3*BYTES  per-source K-char flags.
- tx_valid  out  1  output beat valid.
- tx_ready  in  1  downstream accepts the beat.
- tx_data  out  DATA_WIDTH  muxed data.
- tx_datak  out  BYTES  muxed K flags.
- grant  out  2  current owner (0..2); 3 = none.
- wdog_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset: state=IDLE, grant=3, rr_last=2, beat_cnt=0, wdog_err=0. All outputs low except grant.
- FSM states: IDLE, BUSY, FLUSH.
- IDLE: req_ready=0, tx_valid=0.
  - Candidates are sources with req_valid & req_sop.
  - Req 0 wins if it is a candidate. Otherwise, among 1 and 2, the one not equal to rr_last wins if it is a candidate, else the other.
  - On a winner: register grant, go to BUSY next cycle. Decision latency is 1 cycle.
  - Valid beats with sop=0 are ignored and left unaccepted.
- BUSY (g = grant):
  - tx_valid = req_valid[g]; tx_data/tx_datak = source g fields, combinational.
  - req_ready[g] = tx_ready; all other req_ready are 0.
  - A beat transfers when tx_valid & tx_ready.
  - Each transfer increments beat_cnt (saturating at MAX_PKT_BEATS).
  - On a transfer with req_eop[g]=1: go to IDLE, grant=3, beat_cnt=0, and rr_last=g if g≠0 (unchanged if g=0).
  - SOP+EOP on the same beat (single-beat packet) is legal and handled identically.
  - If no EOP arrives before the transfer that makes beat_cnt = MAX_PKT_BEATS: that beat is passed, then wdog_err pulses and the FSM goes to FLUSH.
- FLUSH: tx_valid=0. req_ready[g]=1, discarding beats of g until a beat with eop (inclusive). Then go to IDLE, grant=3, with the same rr_last update as a normal EOP.
- Backpressure: while tx_ready=0 in BUSY, outputs hold the source values; the source must hold its beat stable (standard valid/ready).
- Simultaneous events:
  - req 0 SOP together with req 1/2 SOP in IDLE → req 0 wins.
  - Req 0 arriving mid-packet of req 2 waits for req 2's EOP.
- Reset mid-packet: returns asynchronously to the reset values. No partial-packet recovery; sources are reset in the same domain.
- Width rule: beat_cnt is $clog2(MAX_PKT_BEATS+1) bits.

Decomposition:
- common_pkg additions:
  - typedef enum {SRC_OS=0, SRC_DLLP=1, SRC_TLP=2, SRC_NONE=3} tx_src_t.
  - typedef enum {ARB_IDLE, ARB_BUSY, ARB_FLUSH} tx_arb_state_t.
  - localparam NUM_TX_SRC=3.
- Sub-module pipe_tx_rr_pick: combinational priority + round-robin selector. Inputs: candidate mask, rr_last. Outputs: winner, found.

Test Plan:
- Only req 2 sends a 4-beat TLP (sop on beat 0, eop on beat 3), tx_ready=1 → grant=2 one cycle after the SOP is presented, 4 consecutive tx beats with matching data, then grant=3.
- Reqs 0, 1 and 2 all present SOP in the same cycle → order of service is 0, then 1, then 2; rr_last=2 at the end.
- Req 2 is in BUSY on beat 2 of 6 when req 0 asserts SOP → req 0 is not granted until after req 2's EOP, then granted in the first IDLE decision.
- MAX_PKT_BEATS=8, req 1 streams 12 beats with eop on beat 11 → 8 beats out, wdog_err pulses once, beats 8..11 are consumed with tx_valid=0, then IDLE.
- tx_ready toggles 1,0,0,1 during a 3-beat packet → tx_data is held stable while stalled, and req_ready mirrors tx_ready.
- reset_n is pulled low mid-packet, asynchronously → grant=3 and tx_valid=0 immediately, without waiting for a clock edge; after release a fresh SOP from req 1 is granted.
